// File: rtl/encoder_level_if.sv
// Encoder-side bundle: raw quadrature inputs in, level and change pulse out.
// The encoder block uses the slave modport; the rotary encoder source uses master.
interface encoder_level_if #(
  parameter int WIDTH = 8
);
  logic             enc_a;
  logic             enc_b;
  logic [WIDTH-1:0] level;
  logic             changed;

  modport master (
    output enc_a,
    output enc_b,
    input  level,
    input  changed
  );

  modport slave (
    input  enc_a,
    input  enc_b,
    output level,
    output changed
  );
endinterface

// File: rtl/encoder_level.sv
// Quadrature rotary encoder to level register: sync, per-channel debounce,
// x1 decode on filtered A rising edge, and saturating or wrapping accumulation.
module encoder_level #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STEP            = 1,
  parameter int WRAP            = 0,
  parameter int RESET_LEVEL     = 0
) (
  input logic           clk,
  input logic           reset,
  encoder_level_if.slave bus
);

  localparam int              CW        = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]   CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH:0]  STEP_EXT  = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH:0]  LEVEL_MAX = {1'b0, {WIDTH{1'b1}}};

  // Channel 0 is A, channel 1 is B.
  logic          raw       [2];
  logic          sync1_reg [2];
  logic          sync2_reg [2];
  logic          filt_reg  [2];
  logic [CW-1:0] cnt_reg   [2];

  assign raw[0] = bus.enc_a;
  assign raw[1] = bus.enc_b;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_reg[gi] <= 1'b0;
          sync2_reg[gi] <= 1'b0;
          filt_reg[gi]  <= 1'b0;
          cnt_reg[gi]   <= '0;
        end else begin
          sync1_reg[gi] <= raw[gi];
          sync2_reg[gi] <= sync1_reg[gi];
          // Counter only runs while the input disagrees, and is cleared on
          // acceptance, so it never exceeds DEBOUNCE_CYCLES-1.
          if (sync2_reg[gi] == filt_reg[gi]) begin
            cnt_reg[gi] <= '0;
          end else if (cnt_reg[gi] == CNT_LAST) begin
            filt_reg[gi] <= sync2_reg[gi];
            cnt_reg[gi]  <= '0;
          end else begin
            cnt_reg[gi] <= cnt_reg[gi] + CW'(1);
          end
        end
      end
    end
  endgenerate

  logic             prev_a_reg;
  logic [WIDTH-1:0] level_reg;
  logic             changed_reg;

  logic             step;
  logic             down;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;
  logic [WIDTH-1:0] level_next;
  logic             changed_next;

  assign step = filt_reg[0] & ~prev_a_reg;
  assign down = filt_reg[1];

  always_comb begin
    sum          = {1'b0, level_reg} + STEP_EXT;
    diff         = {1'b0, level_reg} - STEP_EXT;
    inc_val      = sum[WIDTH-1:0];
    dec_val      = diff[WIDTH-1:0];
    // A borrow out of the subtraction shows up as the extra top bit.
    if (WRAP == 0) begin
      if (sum > LEVEL_MAX) inc_val = {WIDTH{1'b1}};
      if (diff[WIDTH])     dec_val = '0;
    end
    level_next   = level_reg;
    if (step) level_next = down ? dec_val : inc_val;
    changed_next = (level_next != level_reg);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_a_reg  <= 1'b0;
      level_reg   <= WIDTH'(RESET_LEVEL);
      changed_reg <= 1'b0;
    end else begin
      prev_a_reg  <= filt_reg[0];
      level_reg   <= level_next;
      changed_reg <= changed_next;
    end
  end

  assign bus.level   = level_reg;
  assign bus.changed = changed_reg;

endmodule

// File: tb/tb_encoder_level.sv
// Directed bench: three encoder_level instances (default, STEP=2 saturating,
// WRAP=1) each with their own encoder inputs and a shared reset.
module tb_encoder_level;

  logic clk;
  logic reset;
  logic a_d, b_d, a_s, b_s, a_w, b_w;
  int   checks;
  int   errors;
  int   pulses_d, pulses_s, pulses_w;

  encoder_level_if #(.WIDTH(8)) if_d ();
  encoder_level_if #(.WIDTH(8)) if_s ();
  encoder_level_if #(.WIDTH(8)) if_w ();

  assign if_d.enc_a = a_d;
  assign if_d.enc_b = b_d;
  assign if_s.enc_a = a_s;
  assign if_s.enc_b = b_s;
  assign if_w.enc_a = a_w;
  assign if_w.enc_b = b_w;

  encoder_level #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .STEP(1), .WRAP(0), .RESET_LEVEL(0)) dut_d (
    .clk(clk), .reset(reset), .bus(if_d.slave));
  encoder_level #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .STEP(2), .WRAP(0), .RESET_LEVEL(0)) dut_s (
    .clk(clk), .reset(reset), .bus(if_s.slave));
  encoder_level #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .STEP(1), .WRAP(1), .RESET_LEVEL(0)) dut_w (
    .clk(clk), .reset(reset), .bus(if_w.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (if_d.changed) pulses_d++;
    if (if_s.changed) pulses_s++;
    if (if_w.changed) pulses_w++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_ab(input int idx, input logic a, input logic b);
    case (idx)
      0: begin a_d = a; b_d = b; end
      1: begin a_s = a; b_s = b; end
      default: begin a_w = a; b_w = b; end
    endcase
  endtask

  // One full detent: settle B to the direction, pulse A high then low.
  task automatic rotate(input int idx, input logic dn);
    set_ab(idx, 1'b0, dn);
    wait_n(12);
    set_ab(idx, 1'b1, dn);
    wait_n(12);
    set_ab(idx, 1'b0, dn);
    wait_n(12);
  endtask

  // Raise A on the default instance and check level changes exactly at edge 7.
  task automatic latency_check(input string tag, input logic [7:0] old_lvl, input logic [7:0] new_lvl);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check({tag, "_hold_level"}, if_d.level, old_lvl);
      check({tag, "_hold_changed"}, if_d.changed, 0);
    end
    @(negedge clk);
    check({tag, "_edge7_level"}, if_d.level, new_lvl);
    check({tag, "_edge7_changed"}, if_d.changed, 1);
    @(negedge clk);
    check({tag, "_edge8_level"}, if_d.level, new_lvl);
    check({tag, "_edge8_changed"}, if_d.changed, 0);
  endtask

  initial begin
    int p0;
    checks   = 0;
    errors   = 0;
    pulses_d = 0;
    pulses_s = 0;
    pulses_w = 0;
    reset    = 1'b1;
    a_d = 0; b_d = 0; a_s = 0; b_s = 0; a_w = 0; b_w = 0;

    // Reset held for 20 cycles with both channels low.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 1) begin
        check("reset_level_d", if_d.level, 0);
        check("reset_changed_d", if_d.changed, 0);
        check("reset_level_s", if_s.level, 0);
        check("reset_level_w", if_w.level, 0);
      end
    end
    reset = 1'b0;
    wait_n(4);
    check("post_reset_level", if_d.level, 0);

    // Increment with B low, exact latency.
    a_d = 1'b1;
    latency_check("inc", 8'd0, 8'd1);
    a_d = 1'b0;
    wait_n(12);
    b_d = 1'b1;
    wait_n(12);
    check("b_only_no_step", if_d.level, 1);
    // Decrement with B high.
    a_d = 1'b1;
    latency_check("dec", 8'd1, 8'd0);
    a_d = 1'b0;
    wait_n(12);
    b_d = 1'b0;
    wait_n(12);
    check("a_fall_no_step", if_d.level, 0);

    // Glitches on A shorter than the debounce window are rejected.
    p0 = pulses_d;
    for (int len = 1; len <= 3; len++) begin
      a_d = 1'b1;
      wait_n(len);
      a_d = 1'b0;
      wait_n(12);
      check("glitch_level", if_d.level, 0);
      check("glitch_pulses", pulses_d, p0);
    end
    a_d = 1'b1;
    wait_n(4);
    a_d = 1'b0;
    wait_n(12);
    check("pulse4_level", if_d.level, 1);
    check("pulse4_pulses", pulses_d, p0 + 1);

    // STEP=2 saturating instance.
    for (int i = 0; i < 127; i++) rotate(1, 1'b0);
    check("s2_preload_level", if_s.level, 254);
    check("s2_preload_pulses", pulses_s, 127);
    rotate(1, 1'b0);
    check("s2_sat_hi_level", if_s.level, 255);
    check("s2_sat_hi_pulses", pulses_s, 128);
    rotate(1, 1'b0);
    check("s2_clamp_hi_level", if_s.level, 255);
    check("s2_clamp_hi_pulses", pulses_s, 128);
    for (int i = 0; i < 127; i++) rotate(1, 1'b1);
    check("s2_down_level", if_s.level, 1);
    check("s2_down_pulses", pulses_s, 255);
    rotate(1, 1'b1);
    check("s2_sat_lo_level", if_s.level, 0);
    check("s2_sat_lo_pulses", pulses_s, 256);
    rotate(1, 1'b1);
    check("s2_clamp_lo_level", if_s.level, 0);
    check("s2_clamp_lo_pulses", pulses_s, 256);

    // WRAP=1 instance.
    rotate(2, 1'b1);
    check("wrap_dec_level", if_w.level, 255);
    check("wrap_dec_pulses", pulses_w, 1);
    rotate(2, 1'b0);
    check("wrap_inc_level", if_w.level, 0);
    check("wrap_inc_pulses", pulses_w, 2);

    // Reset two cycles into a valid A rise discards it.
    a_d = 1'b1;
    wait_n(2);
    reset = 1'b1;
    @(negedge clk);
    check("midreset_level", if_d.level, 0);
    a_d = 1'b0;
    wait_n(3);
    p0 = pulses_d;
    reset = 1'b0;
    wait_n(15);
    check("midreset_after_level", if_d.level, 0);
    check("midreset_after_pulses", pulses_d, p0);
    check("midreset_level_s", if_s.level, 0);

    // A held high across reset release yields exactly one increment.
    a_d = 1'b1;
    reset = 1'b1;
    wait_n(4);
    reset = 1'b0;
    p0 = pulses_d;
    latency_check("held_a", 8'd0, 8'd1);
    wait_n(20);
    check("held_a_final_level", if_d.level, 1);
    check("held_a_pulses", pulses_d, p0 + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
